// File: rtl/space_invaders_pkg.sv
// Shared constants and debounce FSM state encoding for the space-invaders board logic.
// Used by button_debouncer and debounce_channel (optional feature macro: AUTOREPEAT_EN).
`timescale 1ns/1ps
package space_invaders_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 360000;    // 10 ms @ 36 MHz
    localparam int unsigned REPEAT_DELAY_DEFAULT    = 10800000;  // 300 ms
    localparam int unsigned REPEAT_PERIOD_DEFAULT   = 3600000;   // 100 ms

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    // One counter width covers debounce and both repeat intervals.
    function automatic int unsigned deb_cnt_width(input int unsigned a,
                                                  input int unsigned b,
                                                  input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, press/release FSM and registered pulse.
// Repeat counter is built only when REPEAT_ON=1 and AUTOREPEAT_EN is defined.
`timescale 1ns/1ps
module debounce_channel
    import space_invaders_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
    parameter bit          BTN_ACTIVE      = 1'b1,
    parameter bit          REPEAT_ON       = 1'b0
)(
    input  logic clk_36MHz,
    input  logic reset,
    input  logic i_raw,
    output logic o_pulse
);

    // state        | meaning
    // IDLE         | button released and stable
    // PRESS_WAIT   | pressed, counting stable samples before accepting
    // HELD         | press accepted; optional repeat timing runs here
    // RELEASE_WAIT | released, counting stable samples before returning to IDLE

    localparam int unsigned CNT_W = deb_cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    logic             w_s;
    logic             w_rep_fire;
    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pulse_nxt;

    always_ff @(posedge clk_36MHz or negedge reset) begin
        if (!reset) begin
            r_sync1 <= ~BTN_ACTIVE;
            r_sync2 <= ~BTN_ACTIVE;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = (r_sync2 == BTN_ACTIVE);

    always_ff @(posedge clk_36MHz or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_s) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = HELD;
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                // A release seen on the same cycle as a repeat wins: no pulse.
                if (!w_s) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end else if (w_rep_fire) begin
                    w_pulse_nxt = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (w_s) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    generate
        if (REPEAT_ON) begin : g_rep
`ifdef AUTOREPEAT_EN
            localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
            localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

            logic [CNT_W-1:0] r_rep_cnt;
            logic             r_rep_first;
            logic             w_held_entry;

            assign w_held_entry = (r_state == PRESS_WAIT) && w_s && (r_cnt == DEB_LAST);
            assign w_rep_fire   = (r_state == HELD) && w_s &&
                                  (r_rep_cnt == (r_rep_first ? DELAY_LAST : PERIOD_LAST));

            // Frozen outside HELD so a bounce through RELEASE_WAIT resumes the interval.
            always_ff @(posedge clk_36MHz or negedge reset) begin
                if (!reset) begin
                    r_rep_cnt   <= '0;
                    r_rep_first <= 1'b1;
                end else if (w_held_entry) begin
                    r_rep_cnt   <= '0;
                    r_rep_first <= 1'b1;
                end else if ((r_state == HELD) && w_s) begin
                    if (w_rep_fire) begin
                        r_rep_cnt   <= '0;
                        r_rep_first <= 1'b0;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + 1'b1;
                    end
                end
            end
`else
            assign w_rep_fire = 1'b0;
`endif
        end else begin : g_norep
            assign w_rep_fire = 1'b0;
        end
    endgenerate

    assign o_pulse = r_pulse;

endmodule

// File: rtl/button_debouncer.sv
// Debounces left/right/fire buttons into single-cycle pulses with left/right exclusion
// and enable gating. Define AUTOREPEAT_EN to auto-repeat left/right while held.
`timescale 1ns/1ps
module button_debouncer
    import space_invaders_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
    parameter bit          BTN_ACTIVE      = 1'b1
)(
    input  logic clk_36MHz,
    input  logic reset,
    input  logic enable,
    input  logic left_raw,
    input  logic right_raw,
    input  logic fire_raw,
    output logic left_debounced,
    output logic right_debounced,
    output logic fire_debounced
);

`ifdef AUTOREPEAT_EN
    localparam bit LR_REPEAT = 1'b1;
`else
    localparam bit LR_REPEAT = 1'b0;
`endif

    logic w_left_pulse;
    logic w_right_pulse;
    logic w_fire_pulse;
    logic w_lr_clash;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .BTN_ACTIVE      (BTN_ACTIVE),
        .REPEAT_ON       (LR_REPEAT)
    ) u_left (
        .clk_36MHz (clk_36MHz),
        .reset     (reset),
        .i_raw     (left_raw),
        .o_pulse   (w_left_pulse)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .BTN_ACTIVE      (BTN_ACTIVE),
        .REPEAT_ON       (LR_REPEAT)
    ) u_right (
        .clk_36MHz (clk_36MHz),
        .reset     (reset),
        .i_raw     (right_raw),
        .o_pulse   (w_right_pulse)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .BTN_ACTIVE      (BTN_ACTIVE),
        .REPEAT_ON       (1'b0)
    ) u_fire (
        .clk_36MHz (clk_36MHz),
        .reset     (reset),
        .i_raw     (fire_raw),
        .o_pulse   (w_fire_pulse)
    );

    // Opposite moves in one cycle cancel; the channels keep running regardless.
    assign w_lr_clash      = w_left_pulse & w_right_pulse;
    assign left_debounced  = enable & w_left_pulse  & ~w_lr_clash;
    assign right_debounced = enable & w_right_pulse & ~w_lr_clash;
    assign fire_debounced  = enable & w_fire_pulse;

endmodule
